text_console: RTL and testbench
===============================

Name: text_console

Overview:
- Sequences the system-side write port of the text-mode RAM (tram), turning a byte stream of characters and control codes into word writes at a cursor position.
- Owns the cursor, line wrap, hardware scrolling (drives `scroll_offs` for the text mode renderer) and screen clear.
- Sits in the clk_sys domain between a future CPU/UART source and the tram system port.

Parameters:
- WORD, 32, tram word width (bits)
- BYTE_CNT, 4, tram byte-enable width
- ADDRW, 11, tram address width
- TEXT_HRES, 84, characters per line
- TEXT_VRES, 24, lines on screen
- CHARW, 8, input character width
- CIDXW, 4, foreground/background colour index width

Ports:
- clk_sys  in  1  system clock
- rst_sys  in  1  reset, asynchronous, active-high
- in_valid  in  1  character/control code valid
- in_ready  out  1  block accepts in_char this cycle
- in_char  in  CHARW  character or control code
- attr_fg  in  CIDXW  foreground colour, sampled on accept
- attr_bg  in  CIDXW  background colour, sampled on accept
- tram_we  out  BYTE_CNT  tram byte write enables (all-ones or zero)
- tram_addr  out  ADDRW  tram write address
- tram_din  out  WORD  tram write data
- scroll_offs  out  ADDRW  physical address of top screen line, to textmode
- cursor_col  out  7  cursor column 0..TEXT_HRES-1
- cursor_row  out  5  cursor row 0..TEXT_VRES-1
- busy  out  1  high during line or screen clear

Behaviour:
- Interface: one clock, clk_sys. Reset rst_sys is asynchronous and active-high.
- Reset values:
  - Outputs: in_ready=0, tram_we=0, tram_addr=0, tram_din=0, scroll_offs=0, cursor 0/0, busy=0.
  - Internal: line_base=0, state=IDLE.
  - in_ready rises the first cycle after reset release.
- DEPTH = TEXT_HRES*TEXT_VRES (2016).
- Word format: [31:28] fg, [27:24] bg, [23:CHARW] zero, [CHARW-1:0] code. Blank = code 0x20 with last-accepted attrs.
- Address arithmetic:
  - Write address = line_base + cursor_col.
  - line_base and scroll_offs are multiples of TEXT_HRES and < DEPTH.
  - Advance by TEXT_HRES uses compare-and-subtract wrap at DEPTH. No dividers.
- All tram outputs are registered. A code accepted in cycle N produces a write in cycle N+1. tram_we is high for exactly one cycle per write.
- Handshake: accept when in_valid && in_ready. in_ready = (state==IDLE). In IDLE, printables are accepted back-to-back, one per cycle.
- States:
  - IDLE, handling of accepted codes:
    - Printable (not in 0x08/0x0A/0x0C/0x0D): write at cursor, then col+1.
      - At col==HRES-1: col=0 and perform newline.
    - 0x0D CR: col=0, no write.
    - 0x08 BS: col-1 if col>0, otherwise no-op. No erase, no write.
    - 0x0A LF: newline, col unchanged.
    - 0x0C FF: go to CLR_ALL.
  - Newline:
    - row<VRES-1: row+1, line_base+=HRES (wrap).
    - row==VRES-1: row stays, line_base=scroll_offs, scroll_offs+=HRES (wrap), go to CLR_LINE.
  - CLR_LINE:
    - Writes blank to line_base+0 .. line_base+HRES-1, one per cycle, HRES cycles.
    - busy=1, then return to IDLE.
    - Wrapped printable at last column: the character write happens first, then the clear.
  - CLR_ALL:
    - Writes blank to addresses 0..DEPTH-1, DEPTH cycles.
    - On completion: scroll_offs=0, line_base=0, cursor 0/0, IDLE.
- Boundaries:
  - scroll_offs wraps DEPTH-HRES → 0.
  - Cursor never leaves range.
  - in_valid held during busy is not consumed.
- Reset mid-clear: abort immediately; tram_we=0 asynchronously. Tram contents are undefined.
- scroll_offs changes only in clk_sys. The consumer resynchronises at frame start (out of scope).

Decomposition:
- Shared package (tram/text constants):
  - TEXT_HRES, TEXT_VRES, DEPTH
  - Control codes CC_BS/CC_LF/CC_FF/CC_CR, BLANK_CODE
  - Attribute bit positions
  - State encoding
- One sub-module is natural: text_console_wrap_add (ADDRW adder with modulo-DEPTH wrap), used for line_base and scroll_offs.

Test Plan (defaults: HRES=84, VRES=24):
- Reset release, send 0x41 with fg=F, bg=0 → next cycle we=4'hF, addr=0, din=32'hF000_0041; cursor_col=1.
- 84 back-to-back printables from 0/0 → addrs 0..83 on consecutive cycles, in_ready never drops; cursor 0/1; next write addr 84.
- Cursor row 23, LF → scroll_offs=84; busy and !in_ready for 84 cycles; blank writes (din=32'hF000_0020 for fg=F, bg=0) to addrs 0..83; row stays 23; next printable at col-matching addr in 0..83.
- 24 consecutive LFs at row 23 → scroll_offs steps 84,168,…,1932,0 (wrap). Each clear targets the prior scroll_offs.
- FF → 2016 writes to addrs 0..2015; then scroll_offs=0, cursor 0/0, in_ready=1. CR and BS at col 0 → no write, cursor unchanged.
- rst_sys asserted mid-CLR_ALL (after 500 writes) → tram_we=0 the same cycle (asynchronous). After release, all outputs are at reset values; the first accept writes addr 0.

Source files
------------

// File: rtl/text_console_pkg.sv
// Shared tram/text-mode constants, control codes and state encoding for the text console.
// Also provides the helper that packs a character and its colours into a tram word.
package text_console_pkg;

   localparam int WORD      = 32;
   localparam int BYTE_CNT  = 4;
   localparam int ADDRW     = 11;
   localparam int TEXT_HRES = 84;
   localparam int TEXT_VRES = 24;
   localparam int CHARW     = 8;
   localparam int CIDXW     = 4;
   localparam int DEPTH     = TEXT_HRES * TEXT_VRES;

   localparam logic [6:0]       COL_LAST    = 7'(TEXT_HRES - 1);
   localparam logic [4:0]       ROW_LAST    = 5'(TEXT_VRES - 1);
   localparam logic [ADDRW-1:0] LINE_LAST   = ADDRW'(TEXT_HRES - 1);
   localparam logic [ADDRW-1:0] SCREEN_LAST = ADDRW'(DEPTH - 1);

   localparam logic [CHARW-1:0] CC_BS      = 8'h08;
   localparam logic [CHARW-1:0] CC_LF      = 8'h0A;
   localparam logic [CHARW-1:0] CC_FF      = 8'h0C;
   localparam logic [CHARW-1:0] CC_CR      = 8'h0D;
   localparam logic [CHARW-1:0] BLANK_CODE = 8'h20;

   localparam int FG_LSB = 28;
   localparam int BG_LSB = 24;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLR_LINE,
      ST_CLR_ALL
   } state_e;

   function automatic logic [WORD-1:0] makeWord(input logic [CIDXW-1:0] fg,
                                                input logic [CIDXW-1:0] bg,
                                                input logic [CHARW-1:0] code);
      logic [WORD-1:0] w;
      w                  = '0;
      w[FG_LSB +: CIDXW] = fg;
      w[BG_LSB +: CIDXW] = bg;
      w[CHARW-1:0]       = code;
      return w;
   endfunction

endpackage

// File: rtl/text_console_wrap_add.sv
// Advances a line-aligned tram address by one text line, wrapping at the end of the
// screen buffer with a compare-and-subtract instead of a modulo.
module text_console_wrap_add
   import text_console_pkg::*;
(
   input  logic [ADDRW-1:0] base_i,
   output logic [ADDRW-1:0] next_o
);

   logic [ADDRW:0] sum;

   assign sum    = {1'b0, base_i} + (ADDRW+1)'(TEXT_HRES);
   assign next_o = (sum >= (ADDRW+1)'(DEPTH)) ? ADDRW'(sum - (ADDRW+1)'(DEPTH))
                                              : sum[ADDRW-1:0];

endmodule

// File: rtl/text_console.sv
// Turns a character/control-code stream into registered tram word writes, maintaining
// the cursor, line wrap, hardware scroll offset and line/screen clears.
module text_console
   import text_console_pkg::*;
(
   input  logic                clk_sys,
   input  logic                rst_sys,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CHARW-1:0]    in_char,
   input  logic [CIDXW-1:0]    attr_fg,
   input  logic [CIDXW-1:0]    attr_bg,
   output logic [BYTE_CNT-1:0] tram_we,
   output logic [ADDRW-1:0]    tram_addr,
   output logic [WORD-1:0]     tram_din,
   output logic [ADDRW-1:0]    scroll_offs,
   output logic [6:0]          cursor_col,
   output logic [4:0]          cursor_row,
   output logic                busy
);

   state_e               state_q, state_d;
   logic                 started_q;
   logic [6:0]           col_q, col_d;
   logic [4:0]           row_q, row_d;
   logic [ADDRW-1:0]     lineBase_q, lineBase_d;
   logic [ADDRW-1:0]     scrollOffs_q, scrollOffs_d;
   logic [ADDRW-1:0]     clrCnt_q, clrCnt_d;
   logic [CIDXW-1:0]     fg_q, fg_d, bg_q, bg_d;
   logic [BYTE_CNT-1:0]  we_q, we_d;
   logic [ADDRW-1:0]     addr_q, addr_d;
   logic [WORD-1:0]      din_q, din_d;
   logic [ADDRW-1:0]     lineBaseNext, scrollNext;
   logic                 accept, doNewline;

   text_console_wrap_add uLineAdd (.base_i(lineBase_q),   .next_o(lineBaseNext));
   text_console_wrap_add uScrollAdd (.base_i(scrollOffs_q), .next_o(scrollNext));

   // started_q keeps in_ready low until the first edge after reset is released
   assign in_ready    = started_q && (state_q == ST_IDLE);
   assign accept      = in_valid && in_ready;
   assign busy        = (state_q != ST_IDLE);
   assign tram_we     = we_q;
   assign tram_addr   = addr_q;
   assign tram_din    = din_q;
   assign scroll_offs = scrollOffs_q;
   assign cursor_col  = col_q;
   assign cursor_row  = row_q;

   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys) begin
         state_q      <= ST_IDLE;
         started_q    <= 1'b0;
         col_q        <= '0;
         row_q        <= '0;
         lineBase_q   <= '0;
         scrollOffs_q <= '0;
         clrCnt_q     <= '0;
         fg_q         <= '0;
         bg_q         <= '0;
         we_q         <= '0;
         addr_q       <= '0;
         din_q        <= '0;
      end else begin
         state_q      <= state_d;
         started_q    <= 1'b1;
         col_q        <= col_d;
         row_q        <= row_d;
         lineBase_q   <= lineBase_d;
         scrollOffs_q <= scrollOffs_d;
         clrCnt_q     <= clrCnt_d;
         fg_q         <= fg_d;
         bg_q         <= bg_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         din_q        <= din_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      lineBase_d   = lineBase_q;
      scrollOffs_d = scrollOffs_q;
      clrCnt_d     = clrCnt_q;
      fg_d         = fg_q;
      bg_d         = bg_q;
      we_d         = '0;
      addr_d       = addr_q;
      din_d        = din_q;
      doNewline    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               fg_d = attr_fg;
               bg_d = attr_bg;
               case (in_char)
                  CC_CR: col_d = '0;
                  CC_BS: if (col_q != '0) col_d = col_q - 7'd1;
                  CC_LF: doNewline = 1'b1;
                  CC_FF: begin
                     state_d  = ST_CLR_ALL;
                     clrCnt_d = '0;
                  end
                  default: begin
                     we_d   = '1;
                     addr_d = lineBase_q + ADDRW'(col_q);
                     din_d  = makeWord(attr_fg, attr_bg, in_char);
                     if (col_q == COL_LAST) begin
                        col_d     = '0;
                        doNewline = 1'b1;
                     end else begin
                        col_d = col_q + 7'd1;
                     end
                  end
               endcase
               // On the bottom row the old top line is recycled as the new bottom line
               if (doNewline) begin
                  if (row_q != ROW_LAST) begin
                     row_d      = row_q + 5'd1;
                     lineBase_d = lineBaseNext;
                  end else begin
                     lineBase_d   = scrollOffs_q;
                     scrollOffs_d = scrollNext;
                     clrCnt_d     = '0;
                     state_d      = ST_CLR_LINE;
                  end
               end
            end
         end
         ST_CLR_LINE: begin
            we_d   = '1;
            addr_d = lineBase_q + clrCnt_q;
            din_d  = makeWord(fg_q, bg_q, BLANK_CODE);
            if (clrCnt_q == LINE_LAST) state_d = ST_IDLE;
            else                       clrCnt_d = clrCnt_q + 1'b1;
         end
         ST_CLR_ALL: begin
            we_d   = '1;
            addr_d = clrCnt_q;
            din_d  = makeWord(fg_q, bg_q, BLANK_CODE);
            if (clrCnt_q == SCREEN_LAST) begin
               state_d      = ST_IDLE;
               scrollOffs_d = '0;
               lineBase_d   = '0;
               col_d        = '0;
               row_d        = '0;
            end else begin
               clrCnt_d = clrCnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: a table of single-cycle vectors followed by
// hand-written sequences for wrap, scrolling line clears, full clear and reset abort.
module tb_text_console;
   import text_console_pkg::*;

   logic                clk_sys = 1'b0;
   logic                rst_sys = 1'b1;
   logic                in_valid = 1'b0;
   logic [CHARW-1:0]    in_char = '0;
   logic [CIDXW-1:0]    attr_fg = '0;
   logic [CIDXW-1:0]    attr_bg = '0;
   logic                in_ready;
   logic [BYTE_CNT-1:0] tram_we;
   logic [ADDRW-1:0]    tram_addr;
   logic [WORD-1:0]     tram_din;
   logic [ADDRW-1:0]    scroll_offs;
   logic [6:0]          cursor_col;
   logic [4:0]          cursor_row;
   logic                busy;

   int testCount = 0;
   int failCount = 0;

   typedef struct {
      logic        v;
      logic [7:0]  c;
      logic [3:0]  f;
      logic [3:0]  b;
      logic        expWe;
      logic [10:0] expAddr;
      logic [31:0] expDin;
      logic [6:0]  expCol;
      logic [4:0]  expRow;
   } vec_t;

   vec_t vecs[12];

   text_console dut (
      .clk_sys(clk_sys), .rst_sys(rst_sys), .in_valid(in_valid), .in_ready(in_ready),
      .in_char(in_char), .attr_fg(attr_fg), .attr_bg(attr_bg), .tram_we(tram_we),
      .tram_addr(tram_addr), .tram_din(tram_din), .scroll_offs(scroll_offs),
      .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
   );

   always #5 clk_sys = ~clk_sys;

   // Hard stop in case a sequence gets stuck
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] c, input logic [3:0] f, input logic [3:0] b);
      @(negedge clk_sys);
      in_valid = v;
      in_char  = c;
      attr_fg  = f;
      attr_bg  = b;
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] c, input logic [3:0] f, input logic [3:0] b);
      drive(v, c, f, b);
      tick();
   endtask

   task automatic checkWrite(input string name, input logic [10:0] addr, input logic [31:0] din);
      checkOutput({name, " we"}, 32'(tram_we), 32'hF);
      checkOutput({name, " addr"}, 32'(tram_addr), 32'(addr));
      checkOutput({name, " din"}, tram_din, din);
   endtask

   initial begin
      int expScroll;
      int prior;

      vecs[0]  = '{1'b1, 8'h41, 4'hF, 4'h0, 1'b1, 11'd0,  32'hF000_0041, 7'd1, 5'd0};
      vecs[1]  = '{1'b1, 8'h42, 4'h3, 4'h5, 1'b1, 11'd1,  32'h3500_0042, 7'd2, 5'd0};
      vecs[2]  = '{1'b1, 8'h08, 4'hF, 4'h0, 1'b0, 11'd0,  32'h0,         7'd1, 5'd0};
      vecs[3]  = '{1'b1, 8'h08, 4'hF, 4'h0, 1'b0, 11'd0,  32'h0,         7'd0, 5'd0};
      vecs[4]  = '{1'b1, 8'h08, 4'hF, 4'h0, 1'b0, 11'd0,  32'h0,         7'd0, 5'd0};
      vecs[5]  = '{1'b1, 8'h0D, 4'hF, 4'h0, 1'b0, 11'd0,  32'h0,         7'd0, 5'd0};
      vecs[6]  = '{1'b1, 8'h43, 4'h1, 4'h2, 1'b1, 11'd0,  32'h1200_0043, 7'd1, 5'd0};
      vecs[7]  = '{1'b1, 8'h0A, 4'hF, 4'h0, 1'b0, 11'd0,  32'h0,         7'd1, 5'd1};
      vecs[8]  = '{1'b1, 8'h44, 4'hA, 4'hB, 1'b1, 11'd85, 32'hAB00_0044, 7'd2, 5'd1};
      vecs[9]  = '{1'b1, 8'h0D, 4'hF, 4'h0, 1'b0, 11'd0,  32'h0,         7'd0, 5'd1};
      vecs[10] = '{1'b1, 8'h45, 4'hF, 4'h0, 1'b1, 11'd84, 32'hF000_0045, 7'd1, 5'd1};
      vecs[11] = '{1'b0, 8'h5A, 4'hF, 4'h0, 1'b0, 11'd0,  32'h0,         7'd1, 5'd1};

      $display("[TB] reset checks");
      repeat (3) @(posedge clk_sys);
      #1;
      checkOutput("rst in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst we", 32'(tram_we), 32'd0);
      checkOutput("rst addr", 32'(tram_addr), 32'd0);
      checkOutput("rst din", tram_din, 32'd0);
      checkOutput("rst scroll", 32'(scroll_offs), 32'd0);
      checkOutput("rst col", 32'(cursor_col), 32'd0);
      checkOutput("rst row", 32'(cursor_row), 32'd0);
      checkOutput("rst busy", 32'(busy), 32'd0);
      @(negedge clk_sys);
      rst_sys = 1'b0;
      #1;
      checkOutput("ready before first edge", 32'(in_ready), 32'd0);
      tick();
      checkOutput("ready after release", 32'(in_ready), 32'd1);

      $display("[TB] table vectors");
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].v, vecs[i].c, vecs[i].f, vecs[i].b);
         checkOutput($sformatf("vec%0d we", i), 32'(tram_we), vecs[i].expWe ? 32'hF : 32'h0);
         if (vecs[i].expWe) begin
            checkOutput($sformatf("vec%0d addr", i), 32'(tram_addr), 32'(vecs[i].expAddr));
            checkOutput($sformatf("vec%0d din", i), tram_din, vecs[i].expDin);
         end
         checkOutput($sformatf("vec%0d col", i), 32'(cursor_col), 32'(vecs[i].expCol));
         checkOutput($sformatf("vec%0d row", i), 32'(cursor_row), 32'(vecs[i].expRow));
      end

      $display("[TB] full line of back-to-back printables on row 1");
      applyStimulus(1'b1, CC_CR, 4'hF, 4'h0);
      for (int i = 0; i < 84; i++) begin
         checkOutput($sformatf("line ready %0d", i), 32'(in_ready), 32'd1);
         applyStimulus(1'b1, 8'(8'h30 + (i % 10)), 4'hF, 4'h0);
         checkWrite($sformatf("line char %0d", i), 11'(84 + i), 32'hF000_0030 + 32'(i % 10));
      end
      checkOutput("wrap col", 32'(cursor_col), 32'd0);
      checkOutput("wrap row", 32'(cursor_row), 32'd2);
      applyStimulus(1'b1, 8'h21, 4'hF, 4'h0);
      checkWrite("after wrap", 11'd168, 32'hF000_0021);
      applyStimulus(1'b1, CC_CR, 4'hF, 4'h0);

      $display("[TB] line feeds down to the bottom row");
      for (int i = 0; i < 21; i++) applyStimulus(1'b1, CC_LF, 4'hF, 4'h0);
      checkOutput("bottom row", 32'(cursor_row), 32'd23);
      checkOutput("no scroll yet", 32'(scroll_offs), 32'd0);

      $display("[TB] scrolling line feed with input held while busy");
      applyStimulus(1'b1, CC_LF, 4'hF, 4'h0);
      checkOutput("scroll after LF", 32'(scroll_offs), 32'd84);
      checkOutput("busy after LF", 32'(busy), 32'd1);
      checkOutput("not ready after LF", 32'(in_ready), 32'd0);
      drive(1'b1, 8'h58, 4'hF, 4'h0);
      for (int i = 0; i < 84; i++) begin
         tick();
         checkWrite($sformatf("clr line %0d", i), 11'(i), 32'hF000_0020);
         if (i < 83) checkOutput($sformatf("clr busy %0d", i), 32'(busy), 32'd1);
      end
      checkOutput("clr done busy", 32'(busy), 32'd0);
      checkOutput("clr done ready", 32'(in_ready), 32'd1);
      checkOutput("clr row kept", 32'(cursor_row), 32'd23);
      tick();
      checkWrite("held char", 11'd0, 32'hF000_0058);
      checkOutput("held char col", 32'(cursor_col), 32'd1);
      drive(1'b0, 8'h00, 4'hF, 4'h0);

      $display("[TB] 24 scrolling line feeds");
      expScroll = 84;
      for (int k = 0; k < 24; k++) begin
         prior     = expScroll;
         expScroll = (expScroll + 84 >= 2016) ? expScroll + 84 - 2016 : expScroll + 84;
         applyStimulus(1'b1, CC_LF, 4'hF, 4'h0);
         checkOutput($sformatf("lf%0d scroll", k), 32'(scroll_offs), 32'(expScroll));
         drive(1'b0, 8'h00, 4'hF, 4'h0);
         tick();
         checkWrite($sformatf("lf%0d first clr", k), 11'(prior), 32'hF000_0020);
         repeat (83) tick();
         checkWrite($sformatf("lf%0d last clr", k), 11'(prior + 83), 32'hF000_0020);
         tick();
         checkOutput($sformatf("lf%0d idle", k), 32'(in_ready), 32'd1);
      end

      $display("[TB] screen clear");
      applyStimulus(1'b1, CC_FF, 4'h2, 4'h7);
      checkOutput("ff busy", 32'(busy), 32'd1);
      drive(1'b0, 8'h00, 4'h2, 4'h7);
      for (int i = 0; i < 2016; i++) begin
         tick();
         checkOutput($sformatf("ff addr %0d", i), 32'(tram_addr), 32'(i));
         checkOutput($sformatf("ff din %0d", i), tram_din, 32'h2700_0020);
      end
      checkOutput("ff scroll", 32'(scroll_offs), 32'd0);
      checkOutput("ff col", 32'(cursor_col), 32'd0);
      checkOutput("ff row", 32'(cursor_row), 32'd0);
      checkOutput("ff ready", 32'(in_ready), 32'd1);
      applyStimulus(1'b1, CC_CR, 4'hF, 4'h0);
      checkOutput("cr col0 we", 32'(tram_we), 32'd0);
      checkOutput("cr col0 col", 32'(cursor_col), 32'd0);
      applyStimulus(1'b1, CC_BS, 4'hF, 4'h0);
      checkOutput("bs col0 we", 32'(tram_we), 32'd0);
      checkOutput("bs col0 col", 32'(cursor_col), 32'd0);

      $display("[TB] reset during screen clear");
      applyStimulus(1'b1, 8'h51, 4'hF, 4'h0);
      applyStimulus(1'b1, CC_FF, 4'hF, 4'h0);
      drive(1'b0, 8'h00, 4'hF, 4'h0);
      repeat (500) tick();
      #2;
      rst_sys = 1'b1;
      #1;
      checkOutput("abort we", 32'(tram_we), 32'd0);
      checkOutput("abort busy", 32'(busy), 32'd0);
      checkOutput("abort ready", 32'(in_ready), 32'd0);
      checkOutput("abort addr", 32'(tram_addr), 32'd0);
      checkOutput("abort col", 32'(cursor_col), 32'd0);
      @(negedge clk_sys);
      rst_sys = 1'b0;
      #1;
      checkOutput("abort ready low", 32'(in_ready), 32'd0);
      tick();
      checkOutput("abort ready high", 32'(in_ready), 32'd1);
      applyStimulus(1'b1, 8'h41, 4'hF, 4'h0);
      checkWrite("first after abort", 11'd0, 32'hF000_0041);
      checkOutput("first after abort col", 32'(cursor_col), 32'd1);
      drive(1'b0, 8'h00, 4'h0, 4'h0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
